module_gray_codec_display: RTL

MODULE_GRAY_CODEC_DISPLAY -- requirements
Module: module_gray_codec_display

---
 rtl/module_gray_codec_display.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/module_gray_codec_display.sv
// Gray/binary code sampler with double-dabble BCD conversion and a
// multiplexed active-low seven-segment display driver.
//
// The user code is synchronised every cycle, sampled once per sample
// period ("tick"), decoded to binary, converted to BCD over WIDTH shift
// cycles and then published atomically to the display register. The
// display scans one digit at a time; anode and cathode are registered
// together so they always switch on the same edge.
`timescale 1ns/1ps

module module_gray_codec_display #(
  parameter int WIDTH         = 8,
  parameter int DIGITS        = 3,
  parameter int SAMPLE_PERIOD = 2700000,
  parameter int DIGIT_PERIOD  = 27000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  code_i,
  input  logic              mode_i,
  input  logic              lz_blank_i,
  output logic [WIDTH-1:0]  bin_o,
  output logic              valid_o,
  output logic [DIGITS-1:0] anode_o,
  output logic [6:0]        cathode_o
);

  // ---------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------
  localparam int BCD_W  = 4 * DIGITS;
  localparam int SR_W   = BCD_W + WIDTH;
  localparam int SCNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DCNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STEP_W = $clog2(WIDTH + 1);

  localparam logic [SCNT_W-1:0] SAMPLE_LAST = SCNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [SCNT_W-1:0] SCNT_ZERO   = {SCNT_W{1'b0}};
  localparam logic [SCNT_W-1:0] SCNT_ONE    = SCNT_W'(32'd1);

  localparam logic [DCNT_W-1:0] DIGIT_LAST  = DCNT_W'(DIGIT_PERIOD - 1);
  localparam logic [DCNT_W-1:0] DCNT_ZERO   = {DCNT_W{1'b0}};
  localparam logic [DCNT_W-1:0] DCNT_ONE    = DCNT_W'(32'd1);

  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ZERO    = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(32'd1);

  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(WIDTH - 1);
  localparam logic [STEP_W-1:0] STEP_ZERO   = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(32'd1);

  localparam logic [WIDTH-1:0]  BIN_ZERO    = {WIDTH{1'b0}};
  localparam logic [BCD_W-1:0]  BCD_ZERO    = {BCD_W{1'b0}};
  localparam logic [SR_W-1:0]   SR_ZERO     = {SR_W{1'b0}};

  // Reset display: digit 0 selected, showing '0'.
  localparam logic [DIGITS-1:0] ANODE_RST   = ~(DIGITS'(32'd1));
  localparam logic [6:0]        SEG_ZERO    = 7'b1000000;
  localparam logic [6:0]        SEG_BLANK   = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = BIN_ZERO;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] adj;
    adj = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (adj[WIDTH + 4*d +: 4] >= 4'd5) begin
        adj[WIDTH + 4*d +: 4] = adj[WIDTH + 4*d +: 4] + 4'd3;
      end else begin
        adj[WIDTH + 4*d +: 4] = adj[WIDTH + 4*d +: 4];
      end
    end
    return {adj[SR_W-2:0], 1'b0};
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles blank.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]  code_meta_r;
  logic [WIDTH-1:0]  code_sync_r;
  logic              mode_meta_r;
  logic              mode_sync_r;

  logic [SCNT_W-1:0] sample_cnt_r;
  logic              tick_s;
  logic [WIDTH-1:0]  decoded_s;
  logic [WIDTH-1:0]  bin_r;

  state_t            state_r;
  logic [SR_W-1:0]   shift_r;
  logic [STEP_W-1:0] step_r;
  logic [BCD_W-1:0]  bcd_r;
  logic              valid_r;

  logic [DCNT_W-1:0] digit_cnt_r;
  logic [IDX_W-1:0]  idx_r;

  logic              run_zero_s;
  logic [DIGITS-1:0] blank_s;
  logic [3:0]        sel_nib_s;
  logic              sel_blank_s;
  logic [DIGITS-1:0] next_anode_s;
  logic [6:0]        next_cathode_s;
  logic [DIGITS-1:0] anode_r;
  logic [6:0]        cathode_r;

  // Two-flop synchroniser for the asynchronous code and mode inputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      code_meta_r <= BIN_ZERO;
      code_sync_r <= BIN_ZERO;
      mode_meta_r <= 1'b0;
      mode_sync_r <= 1'b0;
    end else begin
      code_meta_r <= code_i;
      code_sync_r <= code_meta_r;
      mode_meta_r <= mode_i;
      mode_sync_r <= mode_meta_r;
    end
  end

  // Sample counter; the terminal-count cycle is the sampling tick.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sample_cnt_r <= SCNT_ZERO;
    end else if (sample_cnt_r == SAMPLE_LAST) begin
      sample_cnt_r <= SCNT_ZERO;
    end else begin
      sample_cnt_r <= sample_cnt_r + SCNT_ONE;
    end
  end

  assign tick_s = (sample_cnt_r == SAMPLE_LAST);

  // Decode the synchronised code according to the synchronised mode.
  always_comb begin
    decoded_s = BIN_ZERO;
    if (mode_sync_r) begin
      decoded_s = code_sync_r;
    end else begin
      decoded_s = gray_to_bin(code_sync_r);
    end
  end

  // Binary output loads at every tick, whether or not a conversion can start.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bin_r <= BIN_ZERO;
    end else if (tick_s) begin
      bin_r <= decoded_s;
    end else begin
      bin_r <= bin_r;
    end
  end

  // Converter FSM: load on tick, WIDTH double-dabble steps, publish in DONE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      shift_r <= SR_ZERO;
      step_r  <= STEP_ZERO;
      bcd_r   <= BCD_ZERO;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            state_r <= SHIFT;
            shift_r <= {BCD_ZERO, decoded_s};
            step_r  <= STEP_ZERO;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          shift_r <= dabble_step(shift_r);
          if (step_r == STEP_LAST) begin
            state_r <= DONE;
            step_r  <= STEP_ZERO;
          end else begin
            state_r <= SHIFT;
            step_r  <= step_r + STEP_ONE;
          end
        end
        DONE: begin
          // Whole result is copied at once so the display never sees a partial value.
          bcd_r   <= shift_r[WIDTH +: BCD_W];
          valid_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          step_r  <= STEP_ZERO;
        end
      endcase
    end
  end

  // Digit dwell counter and scan index.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      digit_cnt_r <= DCNT_ZERO;
      idx_r       <= IDX_ZERO;
    end else if (digit_cnt_r == DIGIT_LAST) begin
      digit_cnt_r <= DCNT_ZERO;
      if (idx_r == IDX_LAST) begin
        idx_r <= IDX_ZERO;
      end else begin
        idx_r <= idx_r + IDX_ONE;
      end
    end else begin
      digit_cnt_r <= digit_cnt_r + DCNT_ONE;
      idx_r       <= idx_r;
    end
  end

  // Leading-zero map: a digit above 0 blanks when it and everything above it are zero.
  always_comb begin
    run_zero_s = 1'b1;
    blank_s    = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_zero_s = run_zero_s & (bcd_r[4*i +: 4] == 4'd0);
      if ((i > 0) && lz_blank_i && run_zero_s) begin
        blank_s[i] = 1'b1;
      end else begin
        blank_s[i] = 1'b0;
      end
    end
  end

  // Select the current digit and form its anode/cathode drive.
  always_comb begin
    sel_nib_s    = 4'd0;
    sel_blank_s  = 1'b0;
    next_anode_s = {DIGITS{1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        sel_nib_s       = bcd_r[4*i +: 4];
        sel_blank_s     = blank_s[i];
        next_anode_s[i] = 1'b0;
      end else begin
        next_anode_s[i] = 1'b1;
      end
    end
    if (sel_blank_s) begin
      next_cathode_s = SEG_BLANK;
    end else begin
      next_cathode_s = seg7_encode(sel_nib_s);
    end
  end

  // Register anode and cathode together so they switch on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      anode_r   <= ANODE_RST;
      cathode_r <= SEG_ZERO;
    end else begin
      anode_r   <= next_anode_s;
      cathode_r <= next_cathode_s;
    end
  end

  assign bin_o     = bin_r;
  assign valid_o   = valid_r;
  assign anode_o   = anode_r;
  assign cathode_o = cathode_r;

endmodule
